// File: rtl/vga_line_filler.sv
`default_nettype none
// ============================================================================
// Module : vga_line_filler
// Copies one framebuffer line into a two-bank line buffer, one pixel at a time.
// Rev    : 1.0
// ============================================================================
module vga_line_filler #(
  parameter int COLOR_DEPTH = 8,
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int FB_ADDR_W   = 20
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [FB_ADDR_W-1:0]   fb_base,
  input  logic                   line_req,
  input  logic [9:0]             line_num,
  output logic [FB_ADDR_W-1:0]   mem_addr,
  output logic                   mem_rd,
  input  logic                   mem_rdy,
  input  logic [COLOR_DEPTH-1:0] mem_rdata,
  output logic [10:0]            buf_addr,
  output logic [COLOR_DEPTH-1:0] buf_dat,
  output logic                   buf_we,
  output logic                   buf_ce,
  output logic                   busy,
  output logic                   line_done,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [10:0]          c_V_LINES = 11'(V_LINES);
  localparam logic [9:0]           c_X_LAST  = 10'(H_PIXELS - 1);
  localparam logic [FB_ADDR_W-1:0] c_H_PIX   = FB_ADDR_W'(H_PIXELS);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_bank;
  logic [9:0]               r_x;
  logic [FB_ADDR_W-1:0]     r_line_base;
  logic [COLOR_DEPTH-1:0]   r_data;
  logic                     r_overrun;

  logic                     w_req_ok;
  logic                     w_x_last;
  logic                     w_wr;
  logic                     w_ov_set;
  logic [FB_ADDR_W-1:0]     w_line_base;

  // Out-of-range line numbers are dropped everywhere, so every request path keys off w_req_ok.
  assign w_req_ok    = line_req && ({1'b0, line_num} < c_V_LINES);
  assign w_x_last    = (r_x == c_X_LAST);
  assign w_line_base = fb_base + (FB_ADDR_W'(line_num) * c_H_PIX);
  assign w_ov_set    = w_req_ok && ((r_state == S_FETCH) || (r_state == S_WRITE));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = r_state;
      S_FETCH: if (mem_rdy) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_x_last ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A valid request always (re)starts a fill, aborting whatever was in flight.
    if (w_req_ok) begin
      w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_bank      <= 1'b0;
      r_x         <= '0;
      r_line_base <= '0;
      r_data      <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_req_ok) begin
        r_bank      <= line_num[0];
        r_x         <= '0;
        r_line_base <= w_line_base;
      end else begin
        if ((r_state == S_FETCH) && mem_rdy) begin
          r_data <= mem_rdata;
        end
        if ((r_state == S_WRITE) && !w_x_last) begin
          r_x <= r_x + 10'd1;
        end
      end
      if (w_ov_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // The pending pixel is suppressed when a restart lands on its write cycle.
  assign w_wr      = (r_state == S_WRITE) && !w_req_ok;
  assign mem_rd    = (r_state == S_FETCH);
  assign mem_addr  = mem_rd ? (r_line_base + FB_ADDR_W'(r_x)) : '0;
  assign buf_we    = w_wr;
  assign buf_ce    = w_wr;
  assign buf_addr  = (r_state == S_WRITE) ? {r_bank, r_x} : '0;
  assign buf_dat   = (r_state == S_WRITE) ? r_data : '0;
  assign busy      = (r_state != S_IDLE);
  assign line_done = (r_state == S_DONE);
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_filler.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_line_filler
// Scoreboard bench: expected line-buffer writes queued per accepted line.
// Rev    : 1.0
// ============================================================================
module tb_vga_line_filler;

  localparam int CD = 8;
  localparam int H  = 4;
  localparam int V  = 6;
  localparam int AW = 12;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] fb_base = '0;
  logic          line_req = 1'b0;
  logic [9:0]    line_num = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_rdy = 1'b0;
  logic [CD-1:0] mem_rdata;
  logic [10:0]   buf_addr;
  logic [CD-1:0] buf_dat;
  logic          buf_we;
  logic          buf_ce;
  logic          busy;
  logic          line_done;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  vga_line_filler #(
    .COLOR_DEPTH(CD), .H_PIXELS(H), .V_LINES(V), .FB_ADDR_W(AW)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .fb_base(fb_base), .line_req(line_req),
    .line_num(line_num), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .buf_addr(buf_addr), .buf_dat(buf_dat), .buf_we(buf_we),
    .buf_ce(buf_ce), .busy(busy), .line_done(line_done), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [CD-1:0] pixel_of(input int a);
    int t;
    t = a * 37 + (a >> 5) + 11;
    return t[CD-1:0];
  endfunction

  assign mem_rdata = pixel_of(int'(mem_addr));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [10:0]   a;
    logic [CD-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  int            cyc = 0;
  int            accept_cyc = 0;
  bit            ov_m = 0, done_m = 0, busy_m = 0, fast = 0;
  bit            prev_rd = 0, prev_rdy = 0, prev_req = 0;
  logic [AW-1:0] prev_addr = '0;

  // Monitor: reference model advances once per cycle from the observed inputs.
  always @(negedge sys_clk) begin
    bit  req_v, set_ov, dn;
    wr_t w;
    int  base;
    cyc++;
    if (rst) begin
      chk("rst_ctrl", {mem_rd, buf_we, buf_ce, busy, line_done, overrun}, 0);
      chk("rst_data", {mem_addr, buf_addr, buf_dat}, 0);
      exp_q.delete();
      ov_m = 0; done_m = 0; busy_m = 0;
      prev_rd = 0; prev_rdy = 0; prev_req = 0;
    end else begin
      chk("line_done", line_done, done_m);
      chk("busy", busy, busy_m);
      chk("overrun", overrun, ov_m);
      chk("rd_we_excl", mem_rd & buf_we, 0);
      chk("we_eq_ce", buf_we, buf_ce);
      if (line_done && fast) chk("latency", cyc - accept_cyc, 2 * H + 1);
      if (prev_rd && !prev_rdy && !prev_req) begin
        chk("rd_held", mem_rd, 1);
        chk("addr_stable", mem_addr, prev_addr);
      end
      req_v  = line_req && (line_num < V);
      dn     = 0;
      set_ov = 0;
      if (req_v) begin
        chk("abort_no_write", buf_we, 0);
      end else if (buf_we) begin
        chk("write_pending", exp_q.size() == 0, 0);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("buf_addr", buf_addr, w.a);
          chk("buf_dat", buf_dat, w.d);
          if (exp_q.size() == 0) dn = 1;
        end
      end
      if (req_v) begin
        set_ov = (exp_q.size() > 0);
        exp_q.delete();
        base = (int'(fb_base) + int'(line_num) * H) % (1 << AW);
        for (int x = 0; x < H; x++) begin
          w.a = {line_num[0], 10'(x)};
          w.d = pixel_of((base + x) % (1 << AW));
          exp_q.push_back(w);
        end
        accept_cyc = cyc;
      end
      ov_m      = set_ov ? 1'b1 : (overrun_clr ? 1'b0 : ov_m);
      done_m    = dn;
      busy_m    = (exp_q.size() > 0) || dn;
      prev_rd   = mem_rd;
      prev_rdy  = mem_rdy;
      prev_req  = req_v;
      prev_addr = mem_addr;
    end
  end

  // Memory acknowledge: 0 = always ready, 1 = three wait cycles per read, 2 = random.
  int rdy_mode = 0;
  int wcnt = 0;
  always @(posedge sys_clk) begin
    #2;
    case (rdy_mode)
      0: mem_rdy = 1'b1;
      1: begin
        if (mem_rd) begin
          wcnt++;
          mem_rdy = (wcnt == 4);
          if (wcnt == 4) wcnt = 0;
        end else begin
          wcnt = 0;
          mem_rdy = 1'b0;
        end
      end
      default: mem_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic issue(input int ln, input logic [AW-1:0] base, input bit clr);
    line_num    = 10'(ln);
    fb_base     = base;
    line_req    = 1'b1;
    overrun_clr = clr;
    @(posedge sys_clk); #2;
    line_req    = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    rdy_mode = 0;
    fast = 1;
    issue(3, 12'h100, 0);
    idle(12);
    fast = 0;

    rdy_mode = 1;
    issue(5, 12'hFFE, 0);
    idle(30);

    rdy_mode = 0;
    issue(1, 12'h040, 0);
    idle(2);
    issue(2, 12'h040, 1);
    idle(12);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    idle(2);

    issue(V, 12'h200, 0);
    idle(2);
    issue(1, 12'h200, 0);
    idle(1);
    issue(V, 12'h300, 0);
    issue(V + 1, 12'h300, 0);
    idle(10);

    rdy_mode = 2;
    issue(4, 12'h123, 0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge sys_clk); #1;
      if (buf_we) found = 1;
    end
    chk("write_seen_before_reset", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {mem_rd, buf_we, buf_ce, busy, line_done}, 0);
    chk("async_rst_data", {mem_addr, buf_addr, buf_dat}, 0);
    idle(2);
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < 500; i++) begin
      line_req    = ($urandom % 12 == 0);
      line_num    = 10'($urandom_range(0, V + 1));
      fb_base     = AW'($urandom);
      overrun_clr = ($urandom % 10 == 0);
      @(posedge sys_clk); #2;
    end
    line_req    = 1'b0;
    overrun_clr = 1'b0;
    idle(80);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
